// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: turns two raw active-low player keys into one-cycle
// press pulses plus debounced held levels for the tug-of-war playfield.
// Optional feature macro: KEY_DEBOUNCE_EN (defined = debounce FSM present,
// undefined = synchronizer plus registered rising-edge detect only).
module key_pulse_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic Clock,
   input  logic Reset,
   input  logic KeyLn,
   input  logic KeyRn,
   output logic L,
   output logic R,
   output logic LHeld,
   output logic RHeld
);

   localparam int unsigned NUM_CH = 2;

   logic [NUM_CH-1:0] key_n;
   logic [NUM_CH-1:0] pulse;
   logic [NUM_CH-1:0] held;

   assign key_n = {KeyRn, KeyLn};

   // Reject an illegal debounce length at elaboration
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("key_pulse_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam bit          SINGLE_STEP = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      ST_RELEASED   = 2'd0,
      ST_PRESS_PEND = 2'd1,
      ST_HELD       = 2'd2,
      ST_REL_PEND   = 2'd3
   } state_e;
`endif

   // One identical, independent conditioning channel per key
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic sync1_q, sync1_d;
      logic sync2_q, sync2_d;
      logic pulse_q, pulse_d;
      logic held_q,  held_d;

      // Two-flop synchronizer carrying the "pressed" (inverted key) level
      always_comb begin
         sync1_d = ~key_n[ch];
         sync2_d = sync1_q;
      end

`ifdef KEY_DEBOUNCE_EN
      state_e             state_q, state_d;
      logic [CNT_W-1:0]   cnt_q,   cnt_d;

      // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES equal samples
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pulse_d = 1'b0;
         case (state_q)
            ST_RELEASED: begin
               cnt_d = '0;
               if (sync2_q) begin
                  if (SINGLE_STEP) begin
                     state_d = ST_HELD;
                     pulse_d = 1'b1;
                  end else begin
                     state_d = ST_PRESS_PEND;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_PRESS_PEND: begin
               if (!sync2_q) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_HELD: begin
               cnt_d = '0;
               if (!sync2_q) begin
                  if (SINGLE_STEP) begin
                     state_d = ST_RELEASED;
                  end else begin
                     state_d = ST_REL_PEND;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_REL_PEND: begin
               if (sync2_q) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
               end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end
         endcase
         held_d = (state_d == ST_HELD) || (state_d == ST_REL_PEND);
      end

      // Channel registers with synchronous reset
      always_ff @(posedge Clock) begin
         if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
         end
      end
`else
      // Level is sync2 delayed one register; pulse marks its rising edge
      always_comb begin
         held_d  = sync2_q;
         pulse_d = sync2_q & ~held_q;
      end

      // Channel registers with synchronous reset
      always_ff @(posedge Clock) begin
         if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
         end
      end
`endif

      assign pulse[ch] = pulse_q;
      assign held[ch]  = held_q;
   end

   assign L     = pulse[0];
   assign R     = pulse[1];
   assign LHeld = held[0];
   assign RHeld = held[1];

endmodule

// File: doc/key_pulse_conditioner.md
# key_pulse_conditioner

Input conditioning stage for the tug-of-war game. It takes the two raw, asynchronous, active-low player push-buttons and turns each genuine press into a single-cycle, active-high pulse. Those pulses drive the `L`/`R` inputs of every playfield light. The stage provides:
- synchronization of each key into the `Clock` domain;
- optional debounce filtering;
- rising-edge detection, so a held key counts as exactly one move.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive identical synchronized samples required to accept a key level change. Legal range ≥1. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `Clock`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `KeyLn`  in  1  raw left key, active-low (0 = pressed), asynchronous to `Clock`.
- `KeyRn`  in  1  raw right key, active-low, asynchronous to `Clock`.
- `L`      out 1  one-cycle pulse per accepted left press.
- `R`      out 1  one-cycle pulse per accepted right press.
- `LHeld`  out 1  debounced left key level (1 = held).
- `RHeld`  out 1  debounced right key level (1 = held).

## Operation
The two channels are identical and fully independent. Each channel contains the following:
- **Synchronizer:** 2-FF chain sampling the inverted raw key. `sync2` is the synchronized "pressed" level.
- **Debounce FSM**, with states RELEASED, PRESS_PEND, HELD and REL_PEND:
  - RELEASED: if `sync2`=1, go to PRESS_PEND with count=1; otherwise stay, count=0.
  - PRESS_PEND: if `sync2`=0, return to RELEASED with count=0. If `sync2`=1 and count+1 reaches `DEBOUNCE_CYCLES`, go to HELD and assert the pulse register. Otherwise count increments.
  - HELD: if `sync2`=0, go to REL_PEND with count=1.
  - REL_PEND: if `sync2`=1, return to HELD with count=0. If `sync2`=0 and the count reaches `DEBOUNCE_CYCLES`, go to RELEASED. No pulse is ever generated on release.
  - When `DEBOUNCE_CYCLES`=1, RELEASED→HELD happens directly on the first `sync2`=1 sample.
- **Outputs:**
  - `LHeld`/`RHeld` = 1 in HELD and REL_PEND.
  - `L`/`R` are registered and high for exactly one cycle, on the edge that enters HELD.
- **Press behaviour:**
  - A key held indefinitely produces exactly one pulse.
  - A bounce shorter than `DEBOUNCE_CYCLES` samples is absorbed: the count clears and no pulse is produced.
- **Simultaneous presses:** both pulses may assert in the same cycle. Resolving L&R is the responsibility of the downstream light logic.
- **Reset:**
  - Values: all sync FFs 0, state RELEASED, count 0, `L`=`R`=`LHeld`=`RHeld`=0.
  - Reset mid-count: any press in progress is discarded, and no pulse is issued in the cycle after `Reset` deasserts.
  - Key held through reset: after deassertion it is treated as a new press and pulses after the normal latency.

## Timing
- Edge 0 is the first rising edge at which the raw key is sampled pressed.
- With debounce, `L`/`R` are high during the cycle following edge `DEBOUNCE_CYCLES+1`. `LHeld` rises on the same edge.
- Without debounce (see Configuration), `L`/`R` are high during the cycle following edge 2.
- Release latency matches press latency; `LHeld` falls at edge `DEBOUNCE_CYCLES+1` after the release is first sampled.
- Minimum spacing between accepted presses is 2·`DEBOUNCE_CYCLES` cycles (press acceptance plus release acceptance).
- Raw-key glitches shorter than one `Clock` period may or may not be sampled; either outcome is legal.

## Configuration
- `KEY_DEBOUNCE_EN` defined: debounce FSM and counters are present, as described above.
- Not defined:
  - The counters and the PEND states are removed.
  - The debounced level equals `sync2` delayed by one register.
  - `L`/`R` = registered rising edge of `sync2`, giving a fixed 3-edge latency (pulse after edge 2).
  - `DEBOUNCE_CYCLES` is ignored.
  - Used for fast simulation of the full game.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with `KEY_DEBOUNCE_EN` defined unless stated otherwise.
- Clean press: `KeyLn` low for 10 cycles, then high → `L` high for exactly one cycle after edge 5; `LHeld` 1 from edge 5 until 4 stable released samples after release; `R` stays 0.
- Bounced press: `KeyRn` low 2 cycles, high 1, low 8 → exactly one `R` pulse, 4 samples after the final low begins plus the 2-cycle sync delay; no second pulse.
- Short glitch: `KeyLn` low for 3 cycles only → `L` and `LHeld` remain 0 throughout.
- Simultaneous presses: both keys go low on the same edge and are held 8 cycles → `L` and `R` pulse in the same cycle, once each.
- Reset mid-press: `KeyLn` low; assert `Reset` for 1 cycle at count=3, with the key held low throughout → no pulse during or immediately after reset; one `L` pulse arrives a full latency (edge 5) after the first post-reset sampling edge.
- Build without `KEY_DEBOUNCE_EN`: `KeyLn` low for 5 cycles → `L` high for exactly the cycle after edge 2; a 1-cycle low glitch also yields one pulse.
